// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_pkg : shared arbiter state encoding and access-size codes
// Rev 1.0
// ============================================================================
package mem_port_arbiter_pkg;

  localparam logic [2:0] ARB_IDLE   = 3'd0;
  localparam logic [2:0] ARB_I_REQ  = 3'd1;
  localparam logic [2:0] ARB_D_REQ  = 3'd2;
  localparam logic [2:0] ARB_I_WAIT = 3'd3;
  localparam logic [2:0] ARB_D_WAIT = 3'd4;

  // Access size codes, also used by mem_control.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = ARB_IDLE,
    ST_I_REQ  = ARB_I_REQ,
    ST_D_REQ  = ARB_D_REQ,
    ST_I_WAIT = ARB_I_WAIT,
    ST_D_WAIT = ARB_D_WAIT
  } arb_state_t;

  function automatic logic is_data_owner(input arb_state_t s);
    return (s == ST_D_REQ) || (s == ST_D_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_streak.sv
`default_nettype none
// ============================================================================
// arb_streak_ctr : counts back-to-back data grants taken while fetch waits
// Rev 1.0
// ============================================================================
module arb_streak_ctr #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_grant,
  input  logic i_grant_data,
  input  logic i_inst_pending,
  output logic o_starve
);

  generate
    if (MAX_DATA_STREAK == 0) begin : g_no_guard
      // Pure data priority: fetch never forces its way in.
      logic w_unused;
      assign w_unused = ^{clk, rst, i_grant, i_grant_data, i_inst_pending};
      assign o_starve = 1'b0;
    end else begin : g_guard
      localparam int CNT_W = $clog2(MAX_DATA_STREAK + 1);
      localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_DATA_STREAK);

      logic [CNT_W-1:0] r_streak;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_streak <= '0;
        end else if (i_grant) begin
          if (i_grant_data && i_inst_pending) begin
            if (r_streak != c_max_cnt) begin
              r_streak <= r_streak + CNT_W'(1);
            end
          end else begin
            r_streak <= '0;
          end
        end
      end

      assign o_starve = (r_streak == c_max_cnt);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one sram-like port between fetch and data,
//                    data first with a starvation guard for fetch
// Rev 1.0
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t r_state;

  logic w_starve;
  logic w_data_win;
  logic w_sel_data;
  logic w_req_raw;
  logic w_mem_req;
  logic w_accept;

  arb_streak_ctr #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_streak (
    .clk            (clk),
    .rst            (rst),
    .i_grant        (w_accept),
    .i_grant_data   (w_sel_data),
    .i_inst_pending (inst_req),
    .o_starve       (w_starve)
  );

  // Selection is only live in IDLE; once a request is presented the owner is locked.
  always_comb begin
    w_data_win = data_req && !(inst_req && w_starve);
    w_sel_data = 1'b0;
    w_req_raw  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel_data = w_data_win;
        w_req_raw  = data_req || inst_req;
      end
      ST_I_REQ: begin
        w_sel_data = 1'b0;
        w_req_raw  = 1'b1;
      end
      ST_D_REQ: begin
        w_sel_data = 1'b1;
        w_req_raw  = 1'b1;
      end
      default: begin
        w_sel_data = is_data_owner(r_state);
        w_req_raw  = 1'b0;
      end
    endcase
  end

  assign w_mem_req = w_req_raw && !rst;
  assign w_accept  = w_mem_req && mem_addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_req) begin
            if (w_accept) begin
              r_state <= w_sel_data ? ST_D_WAIT : ST_I_WAIT;
            end else begin
              r_state <= w_sel_data ? ST_D_REQ : ST_I_REQ;
            end
          end
        end
        ST_I_REQ: begin
          if (mem_addr_ok) r_state <= ST_I_WAIT;
        end
        ST_D_REQ: begin
          if (mem_addr_ok) r_state <= ST_D_WAIT;
        end
        ST_I_WAIT: begin
          if (mem_data_ok) r_state <= ST_IDLE;
        end
        ST_D_WAIT: begin
          if (mem_data_ok) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = w_mem_req;
  assign mem_wr    = w_sel_data ? data_wr    : 1'b0;
  assign mem_size  = w_sel_data ? data_size  : SIZE_WORD;
  assign mem_addr  = w_sel_data ? data_addr  : inst_addr;
  assign mem_wdata = w_sel_data ? data_wdata : '0;

  assign inst_addr_ok = w_accept && !w_sel_data;
  assign data_addr_ok = w_accept &&  w_sel_data;

  // Completions outside a WAIT state are stale and dropped.
  assign inst_data_ok = !rst && (r_state == ST_I_WAIT) && mem_data_ok;
  assign data_data_ok = !rst && (r_state == ST_D_WAIT) && mem_data_ok;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : two arbiters (streak limit 4 and 0) against a
//                       transaction-level model, directed then random traffic
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        inst_req     [2];
  logic [31:0] inst_addr    [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic [31:0] inst_rdata   [2];
  logic        data_req     [2];
  logic        data_wr      [2];
  logic [1:0]  data_size    [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic [31:0] data_rdata   [2];
  logic        mem_req      [2];
  logic        mem_wr       [2];
  logic [1:0]  mem_size     [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic        mem_addr_ok  [2];
  logic        mem_data_ok  [2];
  logic [31:0] mem_rdata    [2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[0]), .inst_addr(inst_addr[0]), .inst_addr_ok(inst_addr_ok[0]),
    .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
    .data_req(data_req[0]), .data_wr(data_wr[0]), .data_size(data_size[0]),
    .data_addr(data_addr[0]), .data_wdata(data_wdata[0]), .data_addr_ok(data_addr_ok[0]),
    .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
    .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_size(mem_size[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_addr_ok(mem_addr_ok[0]), .mem_data_ok(mem_data_ok[0]),
    .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[1]), .inst_addr(inst_addr[1]), .inst_addr_ok(inst_addr_ok[1]),
    .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
    .data_req(data_req[1]), .data_wr(data_wr[1]), .data_size(data_size[1]),
    .data_addr(data_addr[1]), .data_wdata(data_wdata[1]), .data_addr_ok(data_addr_ok[1]),
    .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
    .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_size(mem_size[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_addr_ok(mem_addr_ok[1]), .mem_data_ok(mem_data_ok[1]),
    .mem_rdata(mem_rdata[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: phase 0 = port free, 1 = owner presented but not yet accepted, 2 = awaiting completion.
  int m_phase  [2];
  bit m_own    [2];   // 1 = data owns the port
  int m_streak [2];
  bit m_acc    [2];
  bit m_iacc   [2];
  bit m_dacc   [2];
  int dcnt     [2];

  logic        s_iaok [2], s_daok [2], s_idok [2], s_ddok [2], s_mreq [2], s_mwr [2];
  logic [1:0]  s_msize [2];
  logic [31:0] s_maddr [2], s_irdata [2];

  function automatic int max_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_check(input int k);
    bit req, own, e_iaok, e_daok, e_idok, e_ddok;
    int nxt;
    req = 0; own = m_own[k]; m_acc[k] = 0;
    e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
    if (rst) begin
      m_phase[k] = 0;
      m_streak[k] = 0;
    end else begin
      if (m_phase[k] == 0) begin
        if (data_req[k] && !(inst_req[k] && max_of(k) != 0 && m_streak[k] == max_of(k))) begin
          req = 1; own = 1;
        end else if (inst_req[k]) begin
          req = 1; own = 0;
        end
      end else if (m_phase[k] == 1) begin
        req = 1;
      end else if (mem_data_ok[k]) begin
        if (own) e_ddok = 1; else e_idok = 1;
        m_phase[k] = 0;
      end
      if (req) begin
        m_own[k] = own;
        if (mem_addr_ok[k]) begin
          m_acc[k] = 1;
          if (own) e_daok = 1; else e_iaok = 1;
          if (own && inst_req[k]) begin
            nxt = m_streak[k] + 1;
            m_streak[k] = (nxt > max_of(k)) ? max_of(k) : nxt;
          end else begin
            m_streak[k] = 0;
          end
          m_phase[k] = 2;
        end else begin
          m_phase[k] = 1;
        end
      end
    end
    chk(k, "mem_req", mem_req[k], req);
    chk(k, "inst_addr_ok", inst_addr_ok[k], e_iaok);
    chk(k, "data_addr_ok", data_addr_ok[k], e_daok);
    chk(k, "inst_data_ok", inst_data_ok[k], e_idok);
    chk(k, "data_data_ok", data_data_ok[k], e_ddok);
    chk(k, "inst_rdata", inst_rdata[k], mem_rdata[k]);
    chk(k, "data_rdata", data_rdata[k], mem_rdata[k]);
    if (req) begin
      chk(k, "mem_addr", mem_addr[k], own ? data_addr[k] : inst_addr[k]);
      chk(k, "mem_wr", mem_wr[k], own ? data_wr[k] : 1'b0);
      chk(k, "mem_size", mem_size[k], own ? data_size[k] : 2'd2);
      chk(k, "mem_wdata", mem_wdata[k], own ? data_wdata[k] : 32'h0);
    end
    m_iacc[k] = e_iaok;
    m_dacc[k] = e_daok;
  endtask

  // One clock: sample and check at the falling edge, then hand back 1 time unit past the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s_iaok[k] = inst_addr_ok[k];  s_daok[k] = data_addr_ok[k];
      s_idok[k] = inst_data_ok[k];  s_ddok[k] = data_data_ok[k];
      s_mreq[k] = mem_req[k];       s_mwr[k]  = mem_wr[k];
      s_msize[k] = mem_size[k];     s_maddr[k] = mem_addr[k];
      s_irdata[k] = inst_rdata[k];
      model_check(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                     input logic [1:0] ds, input logic [31:0] da, input logic [31:0] dwd,
                     input bit aok, input bit dok, input logic [31:0] rd);
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = ir; inst_addr[k] = ia;
      data_req[k] = dr; data_wr[k] = dw; data_size[k] = ds; data_addr[k] = da; data_wdata[k] = dwd;
      mem_addr_ok[k] = aok; mem_data_ok[k] = dok; mem_rdata[k] = rd;
    end
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 299) == 0);
    for (int k = 0; k < 2; k++) begin
      if (m_acc[k]) dcnt[k] = $urandom_range(1, 3);
      mem_data_ok[k] = 1'b0;
      if (dcnt[k] > 0) begin
        dcnt[k]--;
        if (dcnt[k] == 0) mem_data_ok[k] = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        mem_data_ok[k] = 1'b1;
      end
      mem_addr_ok[k] = mem_data_ok[k] ? 1'b0 : ($urandom_range(0, 2) != 0);
      mem_rdata[k] = $urandom;
      if (rst || !inst_req[k] || m_iacc[k]) begin
        inst_req[k]  = ($urandom_range(0, 2) != 0);
        inst_addr[k] = $urandom & 32'hFFFF_FFFC;
      end
      if (rst || !data_req[k] || m_dacc[k]) begin
        data_req[k]   = ($urandom_range(0, 2) != 0);
        data_wr[k]    = $urandom_range(0, 1);
        data_size[k]  = 2'($urandom_range(0, 2));
        data_addr[k]  = $urandom;
        data_wdata[k] = $urandom;
      end
    end
  endtask

  bit [5:0] ord0, ord1;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_own[k] = 0; m_streak[k] = 0; dcnt[k] = 0;
      m_acc[k] = 0; m_iacc[k] = 0; m_dacc[k] = 0;
    end
    // Reset with every input active: nothing may leak out.
    rst = 1'b1;
    drv(1, 32'hBFC00000, 1, 1, 2'd2, 32'h80000010, 32'hDEADBEEF, 1, 1, 32'h0);
    cycle();
    chk(0, "rst_mem_req", s_mreq[0], 1'b0);
    chk(0, "rst_iaok", s_iaok[0], 1'b0);
    chk(0, "rst_ddok", s_ddok[0], 1'b0);
    cycle();
    rst = 1'b0;

    // Single fetch.
    drv(1, 32'hBFC00000, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0);
    cycle();
    chk(0, "fetch_iaok", s_iaok[0], 1'b1);
    chk(0, "fetch_addr", s_maddr[0], 32'hBFC00000);
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    cycle();
    chk(0, "fetch_wait_req", s_mreq[0], 1'b0);
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h3C010001);
    cycle();
    chk(0, "fetch_idok", s_idok[0], 1'b1);
    chk(0, "fetch_rdata", s_irdata[0], 32'h3C010001);
    chk(0, "fetch_ddok", s_ddok[0], 1'b0);

    // Contention: data first, fetch right after data completes.
    drv(1, 32'hBFC00004, 1, 1, 2'd2, 32'h80000010, 32'hDEADBEEF, 1, 0, 32'h0);
    cycle();
    chk(0, "cont_daok", s_daok[0], 1'b1);
    chk(0, "cont_wr", s_mwr[0], 1'b1);
    chk(0, "cont_addr", s_maddr[0], 32'h80000010);
    drv(1, 32'hBFC00004, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0);
    cycle();
    chk(0, "cont_wait_iaok", s_iaok[0], 1'b0);
    drv(1, 32'hBFC00004, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
    cycle();
    chk(0, "cont_ddok", s_ddok[0], 1'b1);
    drv(1, 32'hBFC00004, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0);
    cycle();
    chk(0, "cont_iaok", s_iaok[0], 1'b1);
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
    cycle();

    // Lock: fetch owns the port while data shows up and downstream stalls.
    drv(1, 32'hBFC00008, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    cycle();
    drv(1, 32'hBFC00008, 1, 0, 2'd0, 32'h80000020, 32'h0, 0, 0, 32'h0);
    cycle();
    chk(0, "lock_addr1", s_maddr[0], 32'hBFC00008);
    cycle();
    chk(0, "lock_daok", s_daok[0], 1'b0);
    drv(1, 32'hBFC00008, 1, 0, 2'd0, 32'h80000020, 32'h0, 1, 0, 32'h0);
    cycle();
    chk(0, "lock_iaok", s_iaok[0], 1'b1);
    drv(0, 32'h0, 1, 0, 2'd0, 32'h80000020, 32'h0, 0, 1, 32'h0);
    cycle();
    drv(0, 32'h0, 1, 0, 2'd0, 32'h80000020, 32'h0, 1, 0, 32'h0);
    cycle();
    chk(0, "lock_data_addr", s_maddr[0], 32'h80000020);
    chk(0, "lock_data_size", s_msize[0], 2'd0);
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
    cycle();
    chk(0, "lock_ddok", s_ddok[0], 1'b1);

    // Starvation: both requesters stay high for six transactions.
    for (int i = 0; i < 6; i++) begin
      drv(1, 32'hBFC0000C, 1, 1, 2'd2, 32'h80000030, 32'h12345678, 1, 0, 32'h0);
      cycle();
      ord0[i] = s_daok[0];
      ord1[i] = s_daok[1];
      drv(1, 32'hBFC0000C, 1, 1, 2'd2, 32'h80000030, 32'h12345678, 0, 1, 32'h0);
      cycle();
    end
    chk(0, "starve_order", 32'(ord0), 32'h2F);
    chk(1, "starve_order", 32'(ord1), 32'h3F);
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    cycle();

    // Reset in D_WAIT, then a stale completion.
    drv(0, 32'h0, 1, 0, 2'd2, 32'h80000040, 32'h0, 1, 0, 32'h0);
    cycle();
    chk(0, "rmid_daok", s_daok[0], 1'b1);
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
    cycle();
    chk(0, "rmid_stale_ddok", s_ddok[0], 1'b0);
    drv(1, 32'hBFC00010, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0);
    cycle();
    chk(0, "rmid_next_iaok", s_iaok[0], 1'b1);
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
    cycle();

    // Idle noise.
    drv(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
    cycle();
    chk(0, "noise_mem_req", s_mreq[0], 1'b0);
    chk(0, "noise_idok", s_idok[0], 1'b0);
    chk(0, "noise_ddok", s_ddok[0], 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
